// File: rtl/wr_cell.sv
// wr_cell: one video write channel of the DDR frame writer.
//
// Purpose:
//   Packs incoming pixels into 8*DQ_WIDTH-bit words. Pixel k of each group
//   of eight fills slot k, and each slot is zero-extended to DQ_WIDTH bits.
//   The words are buffered in a show-ahead line FIFO that holds two lines.
//   One DDR burst is requested per complete line, and a word is streamed out
//   on each controller data request. A saturating request-age count tells the
//   arbiter how long this channel has been waiting.
//
// Ports:
//   ddr_clk, ddr_rst   single clock; synchronous active-high reset
//   wr_fsync           frame sync level; a rising edge restarts the frame
//   wr_en, wr_data     pixel valid / pixel
//   ddr_part           static region select, top bits of the burst address
//   ddr_wreq           burst request
//   ddr_waddr          burst start address, in data words
//   ddr_wr_len         burst length, in words (H_NUM/8)
//   ddr_wdone          burst complete; the bus is shared, so it is honoured in DATA only
//   ddr_wdata_req      pops one word from the FIFO
//   ddr_wdata          current FIFO head word
//   frame_wirq         pulse after the last line of a frame is written
//   ddr_wreq_cnt       request age, saturating at 63
//   ddr_wreq_rst       pulse when a frame restart flushes the channel
//
// Configuration:
//   WR_CELL_FRAME_IRQ_EN  when defined, frame_wirq pulses the cycle after the
//                         ddr_wdone that completes line V_NUM-1. Otherwise
//                         frame_wirq is tied to 0.
module wr_cell #(
  parameter int ADDR_WIDTH      = 27,
  parameter int ADDR_OFFSET     = 0,
  parameter int H_NUM           = 1920,
  parameter int V_NUM           = 1080,
  parameter int DQ_WIDTH        = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int PIX_WIDTH       = 24,
  parameter int LINE_ADDR_WIDTH = 19
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rst,
  input  logic                    wr_fsync,
  input  logic                    wr_en,
  input  logic [PIX_WIDTH-1:0]    wr_data,
  input  logic [1:0]              ddr_part,
  output logic                    ddr_wreq,
  output logic [ADDR_WIDTH-1:0]   ddr_waddr,
  output logic [LEN_WIDTH-1:0]    ddr_wr_len,
  input  logic                    ddr_wdone,
  input  logic                    ddr_wdata_req,
  output logic [8*DQ_WIDTH-1:0]   ddr_wdata,
  output logic                    frame_wirq,
  output logic [5:0]              ddr_wreq_cnt,
  output logic                    ddr_wreq_rst
);

  localparam int WORDS      = H_NUM / 8;
  localparam int FIFO_AW    = $clog2(2 * WORDS);
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int LINE_W     = (V_NUM > 1) ? $clog2(V_NUM) : 1;
  localparam int DW         = 8 * DQ_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t state, state_next;

  logic                    fsync_d;
  logic                    fsync_pend;
  logic                    fsync_rise;
  logic                    flush_go;

  logic [2:0]              pix_idx;
  logic [DW-1:0]           pack_word;
  logic [DW-1:0]           commit_word;
  logic                    commit_valid;

  logic [DW-1:0]           mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]      wptr;
  logic [FIFO_AW-1:0]      rptr;
  logic [FIFO_AW:0]        count;
  logic [DW-1:0]           last_word;
  logic                    push;
  logic                    pop;

  logic [LINE_W-1:0]       line_cnt;
  logic [5:0]              req_age;
  logic [LINE_ADDR_WIDTH-1:0] line_off;
  logic [LINE_ADDR_WIDTH+1:0] region_addr;
  logic [ADDR_WIDTH-1:0]   waddr_next;

  // A frame restart must not break a burst that is in progress. An edge seen
  // in DATA is therefore held until the FSM is back in IDLE.
  assign fsync_rise = wr_fsync & ~fsync_d;
  assign flush_go   = (fsync_rise && (state != DATA)) || (fsync_pend && (state == IDLE));

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      fsync_d      <= 1'b0;
      fsync_pend   <= 1'b0;
      ddr_wreq_rst <= 1'b0;
    end else begin
      fsync_d      <= wr_fsync;
      ddr_wreq_rst <= flush_go;
      if (flush_go)
        fsync_pend <= 1'b0;
      else if (fsync_rise && (state == DATA))
        fsync_pend <= 1'b1;
    end
  end

  // The eighth pixel is written straight into commit_word. The next group can
  // then start refilling pack_word while the finished word waits one cycle to
  // be pushed.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst || flush_go) begin
      pix_idx      <= 3'd0;
      pack_word    <= '0;
      commit_word  <= '0;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= 1'b0;
      if (wr_en) begin
        for (int k = 0; k < 8; k++)
          if (pix_idx == 3'(k))
            pack_word[DQ_WIDTH*k +: DQ_WIDTH] <= DQ_WIDTH'(wr_data);
        pix_idx <= pix_idx + 3'd1;
        if (pix_idx == 3'd7) begin
          commit_word  <= {DQ_WIDTH'(wr_data), pack_word[DW-DQ_WIDTH-1:0]};
          commit_valid <= 1'b1;
        end
      end
    end
  end

  assign push = commit_valid && (count != (FIFO_AW+1)'(FIFO_DEPTH)) && !flush_go;
  assign pop  = ddr_wdata_req && (count != '0) && !flush_go;

  always_ff @(posedge ddr_clk) begin
    if (push)
      mem[wptr] <= commit_word;
  end

  // last_word keeps ddr_wdata steady once the FIFO has drained. A pop on an
  // empty FIFO therefore leaves the bus showing the previous word.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst || flush_go) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      last_word <= '0;
    end else begin
      if (push)
        wptr <= wptr + FIFO_AW'(1);
      if (pop) begin
        rptr      <= rptr + FIFO_AW'(1);
        last_word <= mem[rptr];
      end
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end

  assign ddr_wdata = (count != '0) ? mem[rptr] : last_word;

  assign line_off    = LINE_ADDR_WIDTH'(32'(line_cnt) * WORDS);
  assign region_addr = {ddr_part, line_off};
  assign waddr_next  = ADDR_WIDTH'(ADDR_OFFSET) + ADDR_WIDTH'(region_addr);

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // The request drops in the same cycle as the first data request. The
  // arbiter therefore never sees a stale request from a channel it is serving.
  always_comb begin
    state_next   = state;
    ddr_wreq     = 1'b0;
    ddr_wreq_cnt = 6'd0;
    case (state)
      IDLE: if (count >= (FIFO_AW+1)'(WORDS)) state_next = REQ;
      REQ: begin
        ddr_wreq     = !ddr_wdata_req;
        ddr_wreq_cnt = ddr_wdata_req ? 6'd0 : req_age;
        if (ddr_wdata_req) state_next = DATA;
      end
      DATA: if (ddr_wdone) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_go)
      state_next = IDLE;
  end

  // The address and length are captured when a request is raised. They stay
  // stable for the whole request, and the reset value of 0 does not depend on
  // ddr_part.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      line_cnt   <= '0;
      ddr_waddr  <= '0;
      ddr_wr_len <= '0;
      req_age    <= 6'd0;
    end else begin
      if (flush_go)
        line_cnt <= '0;
      else if ((state == DATA) && ddr_wdone)
        line_cnt <= (line_cnt == LINE_W'(V_NUM-1)) ? '0 : line_cnt + LINE_W'(1);
      if ((state == IDLE) && (state_next == REQ)) begin
        ddr_waddr  <= waddr_next;
        ddr_wr_len <= LEN_WIDTH'(WORDS);
      end
      if (state_next == REQ)
        req_age <= (state != REQ) ? 6'd1 : ((req_age == 6'd63) ? 6'd63 : req_age + 6'd1);
      else
        req_age <= 6'd0;
    end
  end

`ifdef WR_CELL_FRAME_IRQ_EN
  logic irq_q;

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst)
      irq_q <= 1'b0;
    else
      irq_q <= (state == DATA) && ddr_wdone && (line_cnt == LINE_W'(V_NUM-1));
  end

  assign frame_wirq = irq_q;
`else
  assign frame_wirq = 1'b0;
`endif

endmodule

// File: tb/tb_wr_cell.sv
// Testbench for wr_cell.
// Inputs are driven 2 time units after each rising clock edge. A queue-based
// behavioural model advances on each rising edge. A compare process checks
// every DUT output against the model on each falling edge, and directed
// steps pin the key values with literals.
module tb_wr_cell;

  localparam int H_NUM = 16;
  localparam int V_NUM = 4;
  localparam int WORDS = H_NUM / 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         ddr_rst;
  logic         wr_fsync;
  logic         wr_en;
  logic [23:0]  wr_data;
  logic [1:0]   ddr_part;
  logic         ddr_wreq;
  logic [26:0]  ddr_waddr;
  logic [15:0]  ddr_wr_len;
  logic         ddr_wdone;
  logic         ddr_wdata_req;
  logic [255:0] ddr_wdata;
  logic         frame_wirq;
  logic [5:0]   ddr_wreq_cnt;
  logic         ddr_wreq_rst;

  int checks = 0;
  int errors = 0;
  int irq_seen = 0;
  bit cmp_en = 1'b0;

  wr_cell #(
    .ADDR_WIDTH(27), .ADDR_OFFSET(0), .H_NUM(H_NUM), .V_NUM(V_NUM),
    .DQ_WIDTH(32), .LEN_WIDTH(16), .PIX_WIDTH(24), .LINE_ADDR_WIDTH(19)
  ) dut (
    .ddr_clk(clk), .ddr_rst(ddr_rst), .wr_fsync(wr_fsync), .wr_en(wr_en),
    .wr_data(wr_data), .ddr_part(ddr_part), .ddr_wreq(ddr_wreq),
    .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len), .ddr_wdone(ddr_wdone),
    .ddr_wdata_req(ddr_wdata_req), .ddr_wdata(ddr_wdata), .frame_wirq(frame_wirq),
    .ddr_wreq_cnt(ddr_wreq_cnt), .ddr_wreq_rst(ddr_wreq_rst)
  );

  always #5 clk = ~clk;

  // The model tracks the channel in words and lines: a queue of buffered
  // words, the pixels of the group being collected, the phase of the current
  // burst and the line number within the frame.
  logic [255:0] m_fifo[$];
  logic [23:0]  m_pix[$];
  logic [255:0] m_cw, m_last;
  bit           m_cv, m_rstp, m_irq, m_pend, m_prev;
  int           m_phase, m_age, m_line, m_waddr, m_len;
  int           m_sz;
  bit           m_rise, m_flush;

  always @(posedge clk) begin
    if (ddr_rst) begin
      m_fifo.delete(); m_pix.delete();
      m_cw = '0; m_last = '0; m_cv = 0; m_rstp = 0; m_irq = 0; m_pend = 0; m_prev = 0;
      m_phase = 0; m_age = 0; m_line = 0; m_waddr = 0; m_len = 0;
    end else begin
      m_sz    = m_fifo.size();
      m_rise  = wr_fsync && !m_prev;
      m_flush = (m_rise && m_phase != 2) || (m_pend && m_phase == 0);
      m_rstp  = m_flush;
`ifdef WR_CELL_FRAME_IRQ_EN
      m_irq   = (m_phase == 2) && ddr_wdone && (m_line == V_NUM - 1);
`else
      m_irq   = 0;
`endif
      if (m_flush) begin
        m_fifo.delete(); m_pix.delete();
        m_cv = 0; m_last = '0; m_line = 0; m_phase = 0; m_age = 0; m_pend = 0;
      end else begin
        if (m_rise && m_phase == 2) m_pend = 1;
        if (ddr_wdata_req && m_sz > 0) m_last = m_fifo.pop_front();
        if (m_cv && m_sz < DEPTH) m_fifo.push_back(m_cw);
        m_cv = 0;
        if (wr_en) begin
          m_pix.push_back(wr_data);
          if (m_pix.size() == 8) begin
            m_cw = '0;
            for (int k = 0; k < 8; k++) m_cw[32*k +: 32] = {8'h00, m_pix[k]};
            m_cv = 1;
            m_pix.delete();
          end
        end
        case (m_phase)
          0: if (m_sz >= WORDS) begin
               m_phase = 1; m_age = 1; m_len = WORDS;
               m_waddr = 0 + ddr_part * (1 << 19) + (m_line * WORDS) % (1 << 19);
             end
          1: if (ddr_wdata_req) begin m_phase = 2; m_age = 0; end
             else m_age = (m_age < 63) ? m_age + 1 : 63;
          default: if (ddr_wdone) begin m_phase = 0; m_line = (m_line + 1) % V_NUM; end
        endcase
      end
      m_prev = wr_fsync;
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!ddr_rst && cmp_en) begin
      checkOutput("cmp_wreq", ddr_wreq, (m_phase == 1) && !ddr_wdata_req);
      checkOutput("cmp_wreq_cnt", ddr_wreq_cnt, ((m_phase == 1) && !ddr_wdata_req) ? m_age : 0);
      checkOutput("cmp_waddr", ddr_waddr, m_waddr);
      checkOutput("cmp_wr_len", ddr_wr_len, m_len);
      checkOutput("cmp_wdata", ddr_wdata, (m_fifo.size() > 0) ? m_fifo[0] : m_last);
      checkOutput("cmp_wreq_rst", ddr_wreq_rst, m_rstp);
      checkOutput("cmp_frame_wirq", frame_wirq, m_irq);
      if (frame_wirq) irq_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic en, input logic [23:0] d, input logic req,
                               input logic done, input logic fs);
    wr_en = en; wr_data = d; ddr_wdata_req = req; ddr_wdone = done; wr_fsync = fs;
  endtask

  task automatic sendPixels(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 24'(base + i), 1'b0, 1'b0, wr_fsync);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic waitWreq();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ddr_wreq) found = 1;
      else tick();
    end
    if (!found) checkOutput("wreq_timeout", 0, 1);
  endtask

  task automatic finishBurst();
    ddr_wdata_req = 1'b1; tick(); tick();
    ddr_wdata_req = 1'b0; ddr_wdone = 1'b1; tick();
    ddr_wdone = 1'b0;
  endtask

  initial begin
    ddr_rst = 1'b1; ddr_part = 2'd1;
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("rst_wreq", ddr_wreq, 0);
    checkOutput("rst_waddr", ddr_waddr, 0);
    checkOutput("rst_wr_len", ddr_wr_len, 0);
    checkOutput("rst_wdata", ddr_wdata, 0);
    checkOutput("rst_wreq_cnt", ddr_wreq_cnt, 0);
    checkOutput("rst_wreq_rst", ddr_wreq_rst, 0);
    checkOutput("rst_frame_wirq", frame_wirq, 0);
    ddr_rst = 1'b0; cmp_en = 1'b1;
    tick();

    $display("[TB] first line and request");
    sendPixels(1, 16);
    waitWreq();
    checkOutput("t1_wreq", ddr_wreq, 1);
    checkOutput("t1_waddr", ddr_waddr, 27'h80000);
    checkOutput("t1_wr_len", ddr_wr_len, 2);
    checkOutput("t1_word0_lo", ddr_wdata[31:0], 32'h00000001);
    checkOutput("t1_word0_hi", ddr_wdata[255:224], 32'h00000008);
    checkOutput("t1_age_start", ddr_wreq_cnt, 1);

    $display("[TB] request age ramp");
    repeat (61) tick();
    checkOutput("t2_age_62", ddr_wreq_cnt, 62);
    repeat (9) tick();
    checkOutput("t2_age_sat", ddr_wreq_cnt, 63);

    $display("[TB] data phase");
    ddr_wdata_req = 1'b1; #1;
    checkOutput("t3_wreq_drop", ddr_wreq, 0);
    checkOutput("t3_age_drop", ddr_wreq_cnt, 0);
    checkOutput("t3_pop0", ddr_wdata[31:0], 32'h1);
    tick();
    checkOutput("t3_pop1_lo", ddr_wdata[31:0], 32'h9);
    checkOutput("t3_pop1_hi", ddr_wdata[255:224], 32'h10);
    tick();
    ddr_wdata_req = 1'b0; #1;
    checkOutput("t3_empty_hold", ddr_wdata[31:0], 32'h9);
    ddr_wdone = 1'b1; tick(); ddr_wdone = 1'b0;
    sendPixels(24'h11, 16);
    waitWreq();
    checkOutput("t3_next_addr", ddr_waddr, 27'h80002);
    checkOutput("t3_line2_word", ddr_wdata[31:0], 32'h11);
    finishBurst();

    $display("[TB] full frame");
    for (int l = 2; l < 4; l++) begin
      sendPixels(32 * l, 16);
      waitWreq();
      checkOutput("t4_addr", ddr_waddr, 27'h80000 + 27'(2 * l));
      finishBurst();
    end
    tick();
`ifdef WR_CELL_FRAME_IRQ_EN
    checkOutput("t4_irq_count", irq_seen, 1);
`else
    checkOutput("t4_irq_count", irq_seen, 0);
`endif
    sendPixels(24'h81, 16);
    waitWreq();
    checkOutput("t4_wrap_addr", ddr_waddr, 27'h80000);
    finishBurst();

    $display("[TB] frame restart in request");
    sendPixels(24'h41, 24);
    waitWreq();
    tick(); tick();
    applyStimulus(1'b1, 24'hBAD, 1'b0, 1'b0, 1'b1);
    tick();
    wr_en = 1'b0;
    checkOutput("t5_rst_pulse", ddr_wreq_rst, 1);
    checkOutput("t5_wreq_off", ddr_wreq, 0);
    tick();
    checkOutput("t5_rst_end", ddr_wreq_rst, 0);
    wr_fsync = 1'b0;
    sendPixels(24'hA1, 8);
    repeat (10) tick();
    checkOutput("t5_fifo_empty", ddr_wreq, 0);
    sendPixels(24'hA9, 8);
    waitWreq();
    checkOutput("t5_addr", ddr_waddr, 27'h80000);
    checkOutput("t5_clean_word", ddr_wdata[31:0], 32'hA1);
    finishBurst();

    $display("[TB] stray burst-done outside data phase");
    ddr_wdone = 1'b1; tick(); ddr_wdone = 1'b0;
    sendPixels(24'h61, 16);
    waitWreq();
    ddr_wdone = 1'b1; tick(); ddr_wdone = 1'b0;
    checkOutput("t6_still_req", ddr_wreq, 1);
    checkOutput("t6_addr", ddr_waddr, 27'h80002);
    finishBurst();

    $display("[TB] frame restart during data phase");
    sendPixels(24'h71, 16);
    waitWreq();
    ddr_wdata_req = 1'b1; tick(); ddr_wdata_req = 1'b0;
    wr_fsync = 1'b1; tick();
    checkOutput("t7_latched", ddr_wreq_rst, 0);
    tick();
    ddr_wdone = 1'b1; tick(); ddr_wdone = 1'b0;
    tick();
    checkOutput("t7_rst_pulse", ddr_wreq_rst, 1);
    wr_fsync = 1'b0;
    repeat (3) tick();
    checkOutput("t7_flushed", ddr_wreq, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
